dmem_responder: RTL and testbench

Multi-cycle data-memory responder: the target side of the core's load/store port. Accepts one request at a time over a valid/ready handshake, models a configurable number of wait states, and commits byte-enabled writes or returns read data over a separate response handshake. Lets pipelined cores be tested against non-zero memory latency and backpressure.

---
 rtl/dmem_rsp_pkg.sv | 18 +
 rtl/dmem_rsp_array.sv | 29 ++
 rtl/dmem_responder.sv | 138 +++++++++++++
 tb/tb_dmem_responder.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/dmem_rsp_pkg.sv
// rtl/dmem_rsp_pkg.sv - shared types, widths and address-error helper for dmem_responder
package dmem_rsp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int BE_W   = 4;
  localparam int DATA_W = 32;

  // Misaligned byte address or word index beyond the array.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_rsp_array.sv
// rtl/dmem_rsp_array.sv - word array with per-byte synchronous write and asynchronous read
module dmem_rsp_array
  import dmem_rsp_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BE_W; i++) begin
      if (we && be[i]) begin
        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder; DMEM_RSP_ERR_CHECK_EN enables address error checks
module dmem_responder
  import dmem_rsp_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CNT_W = (WAIT_STATES > 2) ? $clog2(WAIT_STATES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              capture, acc_fire, rsp_clr;

  logic              lat_we;
  logic [31:0]       lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [BE_W-1:0]   lat_be;

  logic              acc_we, acc_err;
  logic [31:0]       acc_addr;
  logic [DATA_W-1:0] acc_wdata, arr_rdata;
  logic [BE_W-1:0]   acc_be;
  logic [IDX_W-1:0]  acc_idx;

  // With zero wait states the access happens on the accept edge, straight from the request.
  assign acc_we    = (state == IDLE) ? req_we    : lat_we;
  assign acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;
  assign acc_be    = (state == IDLE) ? req_be    : lat_be;
  assign acc_idx   = acc_addr[IDX_W+1:2];

`ifdef DMEM_RSP_ERR_CHECK_EN
  assign acc_err = addr_err(acc_addr, DEPTH_WORDS);
`else
  logic unused_addr;
  assign unused_addr = ^{acc_addr[31:IDX_W+2], acc_addr[1:0]};
  assign acc_err     = 1'b0;
`endif

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    acc_fire   = 1'b0;
    rsp_clr    = 1'b0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          capture = 1'b1;
          if (WAIT_STATES == 0) begin
            acc_fire   = 1'b1;
            state_next = RESP;
          end else begin
            cnt_next   = CNT_INIT;
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          acc_fire   = 1'b1;
          state_next = RESP;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          rsp_clr    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (capture) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
      end
      if (acc_fire) begin
        rsp_rdata <= (acc_we || acc_err) ? '0 : arr_rdata;
        rsp_err   <= acc_err;
      end else if (rsp_clr) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end

  dmem_rsp_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .we   (acc_fire && acc_we && !acc_err),
    .idx  (acc_idx),
    .wdata(acc_wdata),
    .be   (acc_be),
    .rdata(arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed table-driven bench; error expectations follow DMEM_RSP_ERR_CHECK_EN
module tb_dmem_responder;

  localparam int WS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS(1024),
    .WAIT_STATES(WS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered and left at #1 after a posedge with the DUT in IDLE.
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be, input int stall,
                     input logic [31:0] exp_rd, input logic exp_err);
    int lat;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    rsp_ready = 1'b0;
    chk({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rsp_valid) begin
      total++;
      bad++;
      $display("FAIL %s timeout: rsp_valid never rose", tag);
      return;
    end
    chk({tag, " latency"}, 32'(lat), 32'(WS));
    chk({tag, " rdata"}, rsp_rdata, exp_rd);
    chk({tag, " err"}, 32'(rsp_err), 32'(exp_err));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, " hold rdata"}, rsp_rdata, exp_rd);
      chk({tag, " hold err"}, 32'(rsp_err), 32'(exp_err));
      chk({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, " ready after hs"}, 32'(req_ready), 32'd1);
    chk({tag, " valid after hs"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vt[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vt[2]  = '{1'b1, 32'h10,   32'h0000AA00, 4'h2, 32'h0,        1'b0};
    vt[3]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADAAEF, 1'b0};
    vt[4]  = '{1'b1, 32'h0,    32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    vt[5]  = '{1'b1, 32'h14,   32'h01020304, 4'hF, 32'h0,        1'b0};
    vt[6]  = '{1'b1, 32'h14,   32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    vt[7]  = '{1'b0, 32'h14,   32'h0,        4'h0, 32'h01020304, 1'b0};
    vt[8]  = '{1'b1, 32'h14,   32'hAABBCCDD, 4'h9, 32'h0,        1'b0};
    vt[9]  = '{1'b0, 32'h14,   32'h0,        4'h0, 32'hAA0203DD, 1'b0};
`ifdef DMEM_RSP_ERR_CHECK_EN
    vt[10] = '{1'b0, 32'h12,   32'h0,        4'h0, 32'h0,        1'b1};
    vt[11] = '{1'b1, 32'h1000, 32'h12345678, 4'hF, 32'h0,        1'b1};
    vt[12] = '{1'b0, 32'h0,    32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
`else
    vt[10] = '{1'b0, 32'h12,   32'h0,        4'h0, 32'hDEADAAEF, 1'b0};
    vt[11] = '{1'b1, 32'h1000, 32'h12345678, 4'hF, 32'h0,        1'b0};
    vt[12] = '{1'b0, 32'h0,    32'h0,        4'h0, 32'h12345678, 1'b0};
`endif

    // Asynchronous reset asserted mid-cycle takes effect without a clock edge.
    #3 reset = 1'b1;
    #1;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      txn($sformatf("vec%0d", i), vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, 0,
          vt[i].exp_rd, vt[i].exp_err);
    end

    txn("backpressure", 1'b0, 32'h10, 32'h0, 4'h0, 5, 32'hDEADAAEF, 1'b0);

    // Reset during WAIT of a write must leave the array untouched.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h10;
    req_wdata = 32'h11111111;
    req_be    = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("midwrite in wait", 32'(req_ready), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("midwrite reset req_ready", 32'(req_ready), 32'd1);
    chk("midwrite reset rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    txn("after abort", 1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADAAEF, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
